// File: rtl/lvds_1to7_rx_decoder.sv
// 7:1 LVDS receive aligner and VESA 24-bit decoder: drives IDES bitslip from the clock-lane
// word until it matches CLK_PATTERN, then decodes four data lanes to RGB888 + HS/VS/DE.
module lvds_1to7_rx_decoder #(
    parameter logic [6:0]  CLK_PATTERN = 7'b1100011,
    parameter int unsigned SLIP_SETTLE = 4,
    parameter int unsigned LOCK_COUNT  = 16,
    parameter int unsigned LOSS_COUNT  = 4
) (
    input  logic       rx_sclk,
    input  logic       I_rst_n,
    input  logic [6:0] I_clk_word,
    input  logic [6:0] I_lane0,
    input  logic [6:0] I_lane1,
    input  logic [6:0] I_lane2,
    input  logic [6:0] I_lane3,
    output logic       O_bitslip,
    output logic       O_locked,
    output logic [2:0] O_slip_cnt,
    output logic       O_align_err,
    output logic [7:0] O_data_r,
    output logic [7:0] O_data_g,
    output logic [7:0] O_data_b,
    output logic       O_hsync,
    output logic       O_vsync,
    output logic       O_de
);

    typedef enum logic [1:0] {StSearch, StSlipWait, StVerify, StLocked} state_e;

    localparam logic [3:0] WaitLast = 4'(SLIP_SETTLE - 1);
    localparam logic [7:0] GoodLast = 8'(LOCK_COUNT - 1);
    localparam logic [3:0] BadLast  = 4'(LOSS_COUNT - 1);

    state_e     state_q, state_d;
    logic [7:0] good_cnt_q, good_cnt_d;
    logic [3:0] bad_cnt_q, bad_cnt_d;
    logic [3:0] wait_cnt_q, wait_cnt_d;
    logic [2:0] slip_cnt_q, slip_cnt_d;
    logic       bitslip_q, bitslip_d;
    logic       align_err_q, align_err_d;
    logic       locked_q, locked_d;
    logic [7:0] r_q, r_d, g_q, g_d, b_q, b_d;
    logic       hs_q, hs_d, vs_q, vs_d, de_q, de_d;
    logic       match, slip_req;
    logic       unused_rsv;

    assign match      = (I_clk_word == CLK_PATTERN);
    assign unused_rsv = I_lane3[6];

    always_comb begin
        state_d     = state_q;
        good_cnt_d  = good_cnt_q;
        bad_cnt_d   = bad_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        slip_cnt_d  = slip_cnt_q;
        bitslip_d   = 1'b0;
        align_err_d = 1'b0;
        slip_req    = 1'b0;

        unique case (state_q)
            StSearch: begin
                if (match) begin
                    good_cnt_d = 8'd1;
                    state_d    = (LOCK_COUNT == 1) ? StLocked : StVerify;
                end else begin
                    slip_req = 1'b1;
                end
            end
            StSlipWait: begin
                if (wait_cnt_q == WaitLast) begin
                    wait_cnt_d = '0;
                    state_d    = StSearch;
                end else begin
                    wait_cnt_d = wait_cnt_q + 4'd1;
                end
            end
            StVerify: begin
                if (match) begin
                    good_cnt_d = good_cnt_q + 8'd1;
                    if (good_cnt_q == GoodLast) state_d = StLocked;
                end else begin
                    good_cnt_d = '0;
                    slip_req   = 1'b1;
                end
            end
            StLocked: begin
                if (match) begin
                    bad_cnt_d = '0;
                end else if (bad_cnt_q == BadLast) begin
                    bad_cnt_d  = '0;
                    good_cnt_d = '0;
                    slip_cnt_d = '0;
                    state_d    = StSearch;
                end else begin
                    bad_cnt_d = bad_cnt_q + 4'd1;
                end
            end
            default: state_d = StSearch;
        endcase

        // Every slip holds off further slips for SLIP_SETTLE cycles via StSlipWait.
        if (slip_req) begin
            bitslip_d  = 1'b1;
            wait_cnt_d = '0;
            state_d    = StSlipWait;
            if (slip_cnt_q == 3'd6) begin
                slip_cnt_d  = '0;
                align_err_d = 1'b1;
            end else begin
                slip_cnt_d = slip_cnt_q + 3'd1;
            end
        end

        locked_d = (state_d == StLocked);

        // Decode only when locked both before and after this edge; loss of lock zeroes data.
        r_d  = '0;
        g_d  = '0;
        b_d  = '0;
        hs_d = 1'b0;
        vs_d = 1'b0;
        de_d = 1'b0;
        if (locked_q && locked_d) begin
            r_d  = {I_lane3[1:0], I_lane0[5:0]};
            g_d  = {I_lane3[3:2], I_lane1[4:0], I_lane0[6]};
            b_d  = {I_lane3[5:4], I_lane2[3:0], I_lane1[6:5]};
            hs_d = I_lane2[4];
            vs_d = I_lane2[5];
            de_d = I_lane2[6];
        end
    end

    always_ff @(posedge rx_sclk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state_q     <= StSearch;
            good_cnt_q  <= '0;
            bad_cnt_q   <= '0;
            wait_cnt_q  <= '0;
            slip_cnt_q  <= '0;
            bitslip_q   <= 1'b0;
            align_err_q <= 1'b0;
            locked_q    <= 1'b0;
            r_q         <= '0;
            g_q         <= '0;
            b_q         <= '0;
            hs_q        <= 1'b0;
            vs_q        <= 1'b0;
            de_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            good_cnt_q  <= good_cnt_d;
            bad_cnt_q   <= bad_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            slip_cnt_q  <= slip_cnt_d;
            bitslip_q   <= bitslip_d;
            align_err_q <= align_err_d;
            locked_q    <= locked_d;
            r_q         <= r_d;
            g_q         <= g_d;
            b_q         <= b_d;
            hs_q        <= hs_d;
            vs_q        <= vs_d;
            de_q        <= de_d;
        end
    end

    assign O_bitslip   = bitslip_q;
    assign O_locked    = locked_q;
    assign O_slip_cnt  = slip_cnt_q;
    assign O_align_err = align_err_q;
    assign O_data_r    = r_q;
    assign O_data_g    = g_q;
    assign O_data_b    = b_q;
    assign O_hsync     = hs_q;
    assign O_vsync     = vs_q;
    assign O_de        = de_q;

endmodule

// File: tb/tb_lvds_1to7_rx_decoder.sv
// Bench for lvds_1to7_rx_decoder: a deserialiser model that rotates the clock-lane word on each
// bitslip, plus a bit-position decode table and a bad-word run model for lock loss.
module tb_lvds_1to7_rx_decoder;

    localparam logic [6:0] PAT    = 7'b1100011;
    localparam int         SETTLE = 4;
    localparam int         LOCKN  = 16;
    localparam int         LOSSN  = 4;

    logic       rx_sclk = 1'b0;
    logic       I_rst_n = 1'b0;
    logic [6:0] I_clk_word = PAT;
    logic [6:0] I_lane0 = '0, I_lane1 = '0, I_lane2 = '0, I_lane3 = '0;
    logic       O_bitslip, O_locked, O_align_err, O_hsync, O_vsync, O_de;
    logic [2:0] O_slip_cnt;
    logic [7:0] O_data_r, O_data_g, O_data_b;

    int         errors = 0, checks = 0;
    int         cyc, n_slips, last_slip, min_gap, max_gap, n_align_err;
    bit         slip_seen;
    logic [6:0] clk_src;

    lvds_1to7_rx_decoder #(
        .CLK_PATTERN(PAT),
        .SLIP_SETTLE(SETTLE),
        .LOCK_COUNT (LOCKN),
        .LOSS_COUNT (LOSSN)
    ) dut (
        .rx_sclk    (rx_sclk),
        .I_rst_n    (I_rst_n),
        .I_clk_word (I_clk_word),
        .I_lane0    (I_lane0),
        .I_lane1    (I_lane1),
        .I_lane2    (I_lane2),
        .I_lane3    (I_lane3),
        .O_bitslip  (O_bitslip),
        .O_locked   (O_locked),
        .O_slip_cnt (O_slip_cnt),
        .O_align_err(O_align_err),
        .O_data_r   (O_data_r),
        .O_data_g   (O_data_g),
        .O_data_b   (O_data_b),
        .O_hsync    (O_hsync),
        .O_vsync    (O_vsync),
        .O_de       (O_de)
    );

    always #5 rx_sclk = ~rx_sclk;

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [6:0] rotl(input logic [6:0] w);
        return {w[5:0], w[6]};
    endfunction

    function automatic logic [6:0] rotr(input logic [6:0] w);
        return {w[0], w[6:1]};
    endfunction

    // Bit slot k = lane*7 + position, position 0 being the first-received bit[6].
    function automatic logic [26:0] ref_pix(input logic [6:0] l0, input logic [6:0] l1,
                                            input logic [6:0] l2, input logic [6:0] l3);
        logic [27:0] s;
        logic [7:0]  r, g, b;
        int          r_slot[8];
        int          g_slot[8];
        int          b_slot[8];
        s      = {l0, l1, l2, l3};
        r_slot = '{6, 5, 4, 3, 2, 1, 27, 26};
        g_slot = '{0, 13, 12, 11, 10, 9, 25, 24};
        b_slot = '{8, 7, 20, 19, 18, 17, 23, 22};
        for (int i = 0; i < 8; i++) begin
            r[i] = s[27 - r_slot[i]];
            g[i] = s[27 - g_slot[i]];
            b[i] = s[27 - b_slot[i]];
        end
        return {r, g, b, s[27 - 16], s[27 - 15], s[27 - 14]};
    endfunction

    function automatic logic [26:0] pix();
        return {O_data_r, O_data_g, O_data_b, O_hsync, O_vsync, O_de};
    endfunction

    function automatic logic [32:0] all_outs();
        return {O_bitslip, O_locked, O_slip_cnt, O_align_err, O_data_r, O_data_g, O_data_b,
                O_hsync, O_vsync, O_de};
    endfunction

    // One word period: sample outputs at the falling edge, apply slips to the clock lane.
    task automatic tick();
        @(negedge rx_sclk);
        cyc++;
        slip_seen = 1'b0;
        if (O_bitslip === 1'b1) begin
            slip_seen = 1'b1;
            n_slips++;
            if (n_slips > 1) begin
                if (cyc - last_slip < min_gap) min_gap = cyc - last_slip;
                if (cyc - last_slip > max_gap) max_gap = cyc - last_slip;
            end
            last_slip = cyc;
            clk_src   = rotl(clk_src);
        end
        if (O_align_err === 1'b1) n_align_err++;
        I_clk_word = clk_src;
    endtask

    task automatic reset_dut(input logic [6:0] clk_start);
        I_rst_n     = 1'b0;
        clk_src     = clk_start;
        I_clk_word  = clk_start;
        I_lane0     = '0;
        I_lane1     = '0;
        I_lane2     = '0;
        I_lane3     = '0;
        cyc         = 0;
        n_slips     = 0;
        last_slip   = 0;
        min_gap     = 1000;
        max_gap     = 0;
        n_align_err = 0;
        @(negedge rx_sclk);
        @(negedge rx_sclk);
        I_rst_n = 1'b1;
    endtask

    task automatic wait_lock(input int bound, output int ticks);
        ticks = 0;
        while (O_locked !== 1'b1 && ticks < bound) begin
            tick();
            ticks++;
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (all_outs() !== 33'd0) begin
            errors++;
            $display("FAIL reset_initial: got %0h want 0", all_outs());
        end
        @(posedge rx_sclk);
        #1;
        checks++;
        if (all_outs() !== 33'd0) begin
            errors++;
            $display("FAIL reset_held: got %0h want 0", all_outs());
        end
    endtask

    task automatic test_lock_aligned();
        int t;
        reset_dut(PAT);
        wait_lock(60, t);
        checks++;
        if (t !== LOCKN) begin
            errors++;
            $display("FAIL lock_time_aligned: got %0d want %0d", t, LOCKN);
        end
        checks++;
        if (n_slips !== 0) begin
            errors++;
            $display("FAIL no_slip_aligned: got %0d want 0", n_slips);
        end
        checks++;
        if (O_slip_cnt !== 3'd0) begin
            errors++;
            $display("FAIL slip_cnt_aligned: got %0d want 0", O_slip_cnt);
        end
    endtask

    task automatic test_slip_align();
        int t;
        reset_dut(rotr(rotr(rotr(PAT))));
        wait_lock(200, t);
        checks++;
        if (n_slips !== 3) begin
            errors++;
            $display("FAIL slip_count_rot3: got %0d want 3", n_slips);
        end
        checks++;
        if (min_gap < SETTLE + 1) begin
            errors++;
            $display("FAIL slip_spacing_rot3: got %0d want >=%0d", min_gap, SETTLE + 1);
        end
        checks++;
        if (t !== 3 * (SETTLE + 1) + LOCKN) begin
            errors++;
            $display("FAIL lock_time_rot3: got %0d want %0d", t, 3 * (SETTLE + 1) + LOCKN);
        end
        checks++;
        if (O_slip_cnt !== 3'd3) begin
            errors++;
            $display("FAIL slip_cnt_rot3: got %0d want 3", O_slip_cnt);
        end
    endtask

    task automatic test_decode();
        logic [26:0] exp;
        I_lane0 = 7'h7F;
        I_lane1 = 7'h00;
        I_lane2 = 7'b1000000;
        I_lane3 = 7'h00;
        tick();
        checks++;
        if (pix() !== {8'h3F, 8'h01, 8'h00, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL decode_directed: got %0h want %0h", pix(),
                     {8'h3F, 8'h01, 8'h00, 1'b0, 1'b0, 1'b1});
        end
        for (int i = 0; i < 24; i++) begin
            I_lane0 = 7'($urandom);
            I_lane1 = 7'($urandom);
            I_lane2 = 7'($urandom);
            I_lane3 = 7'($urandom);
            exp     = ref_pix(I_lane0, I_lane1, I_lane2, I_lane3);
            tick();
            checks++;
            if (pix() !== exp) begin
                errors++;
                $display("FAIL decode_random[%0d]: got %0h want %0h", i, pix(), exp);
            end
        end
    endtask

    task automatic test_loss();
        int          t, run;
        bit          bad, model_locked;
        logic [26:0] exp;
        reset_dut(PAT);
        wait_lock(60, t);
        model_locked = 1'b1;
        run          = 0;
        for (int i = 0; i < 40 && model_locked; i++) begin
            bad        = ($urandom_range(0, 2) == 0);
            clk_src    = bad ? 7'h00 : PAT;
            I_clk_word = clk_src;
            I_lane0    = 7'($urandom);
            I_lane1    = 7'($urandom);
            I_lane2    = 7'($urandom);
            I_lane3    = 7'($urandom);
            run        = bad ? run + 1 : 0;
            if (run == LOSSN) model_locked = 1'b0;
            exp = model_locked ? ref_pix(I_lane0, I_lane1, I_lane2, I_lane3) : 27'd0;
            tick();
            checks++;
            if (O_locked !== model_locked || pix() !== exp) begin
                errors++;
                $display("FAIL loss_random[%0d]: got lock=%0b pix=%0h want lock=%0b pix=%0h",
                         i, O_locked, pix(), model_locked, exp);
            end
        end
        clk_src    = PAT;
        I_clk_word = PAT;
        wait_lock(60, t);
        tick();
        n_slips = 0;
        I_lane0 = 7'h7F;
        I_lane3 = 7'h3F;
        for (int i = 0; i < 4; i++) begin
            clk_src    = (i < 3) ? 7'h00 : PAT;
            I_clk_word = clk_src;
            tick();
            checks++;
            if (O_locked !== 1'b1) begin
                errors++;
                $display("FAIL loss_three_bad[%0d]: got %0b want 1", i, O_locked);
            end
        end
        for (int i = 0; i < LOSSN; i++) begin
            clk_src    = 7'h00;
            I_clk_word = clk_src;
            tick();
            checks++;
            if (O_locked !== (i < LOSSN - 1)) begin
                errors++;
                $display("FAIL loss_four_bad[%0d]: got %0b want %0b", i, O_locked, i < LOSSN - 1);
            end
        end
        checks++;
        if (pix() !== 27'd0 || n_slips !== 0) begin
            errors++;
            $display("FAIL loss_data_zero: got pix=%0h slips=%0d want 0 0", pix(), n_slips);
        end
        t = 0;
        while (!slip_seen && t < 3) begin
            tick();
            t++;
        end
        checks++;
        if (!slip_seen || O_slip_cnt !== 3'd1) begin
            errors++;
            $display("FAIL loss_research: got slip=%0b cnt=%0d want 1 1", slip_seen, O_slip_cnt);
        end
    endtask

    task automatic test_align_err();
        int t;
        reset_dut(7'h00);
        t = 0;
        while (n_slips < 7 && t < 100) begin
            tick();
            t++;
            if (slip_seen) begin
                checks++;
                if (O_slip_cnt !== 3'(n_slips % 7) || O_align_err !== (n_slips == 7)) begin
                    errors++;
                    $display("FAIL align_slip[%0d]: got cnt=%0d err=%0b want cnt=%0d err=%0b",
                             n_slips, O_slip_cnt, O_align_err, n_slips % 7, n_slips == 7);
                end
            end
        end
        checks++;
        if (n_slips !== 7 || n_align_err !== 1) begin
            errors++;
            $display("FAIL align_err_count: got slips=%0d errs=%0d want 7 1", n_slips,
                     n_align_err);
        end
        checks++;
        if (min_gap !== SETTLE + 1 || max_gap !== SETTLE + 1) begin
            errors++;
            $display("FAIL align_slip_period: got %0d..%0d want %0d", min_gap, max_gap,
                     SETTLE + 1);
        end
    endtask

    task automatic test_reset_mid();
        int t;
        reset_dut(rotr(rotr(rotr(PAT))));
        wait_lock(200, t);
        I_lane0 = 7'h7F;
        I_lane2 = 7'h7F;
        tick();
        checks++;
        if (pix() !== ref_pix(7'h7F, 7'h00, 7'h7F, 7'h00) || O_slip_cnt !== 3'd3) begin
            errors++;
            $display("FAIL pre_reset_state: got pix=%0h cnt=%0d want pix=%0h cnt=3", pix(),
                     O_slip_cnt, ref_pix(7'h7F, 7'h00, 7'h7F, 7'h00));
        end
        #2;
        I_rst_n = 1'b0;
        #1;
        checks++;
        if (all_outs() !== 33'd0) begin
            errors++;
            $display("FAIL reset_async_locked: got %0h want 0", all_outs());
        end
        reset_dut(PAT);
        for (int i = 0; i < 10; i++) tick();
        checks++;
        if (O_locked !== 1'b0) begin
            errors++;
            $display("FAIL verify_not_locked: got %0b want 0", O_locked);
        end
        #2;
        I_rst_n = 1'b0;
        #1;
        checks++;
        if (all_outs() !== 33'd0) begin
            errors++;
            $display("FAIL reset_async_verify: got %0h want 0", all_outs());
        end
        reset_dut(PAT);
        wait_lock(60, t);
        checks++;
        if (t !== LOCKN) begin
            errors++;
            $display("FAIL relock_time: got %0d want %0d", t, LOCKN);
        end
    endtask

    initial begin
        test_reset();
        test_lock_aligned();
        test_slip_align();
        test_decode();
        test_loss();
        test_align_err();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
